// File: rtl/count_sequence_checker.sv
// Checks that a sampled counter bus steps by exactly one in the selected direction.
// Tracks lock, pulses on every error seen while locked, and keeps a saturating error tally.
module count_sequence_checker #(
    parameter int bits       = 4,
    parameter int LOCK_LEN   = 4,
    parameter int UNLOCK_LEN = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             select,
    input  logic [bits-1:0]  count,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [bits-1:0]  last_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [bits-1:0]  STEP_ONE = bits'(1);
    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_LEN);
    localparam logic [3:0]       MISS_TGT = 4'(UNLOCK_LEN);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_t           state_reg;
    logic [3:0]       run_reg;
    logic [3:0]       miss_reg;
    logic             have_prev_reg;
    logic             locked_reg;
    logic             err_pulse_reg;
    logic [ERR_W-1:0] err_count_reg;
    logic [bits-1:0]  last_count_reg;

    logic [bits-1:0]  exp_next;
    logic             match_next;
    logic [3:0]       run_next;
    logic [3:0]       miss_next;

    // Wrapping arithmetic falls out of the bits-wide result.
    assign exp_next   = select ? (last_count_reg + STEP_ONE) : (last_count_reg - STEP_ONE);
    assign match_next = valid && (count == exp_next);
    assign run_next   = run_reg + 4'd1;
    assign miss_next  = miss_reg + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            run_reg        <= '0;
            miss_reg       <= '0;
            have_prev_reg  <= 1'b0;
            locked_reg     <= 1'b0;
            err_pulse_reg  <= 1'b0;
            err_count_reg  <= '0;
            last_count_reg <= '0;
        end else begin
            err_pulse_reg <= 1'b0;
            if (valid) begin
                last_count_reg <= count;
                have_prev_reg  <= 1'b1;
                case (state_reg)
                    IDLE: begin
                        state_reg <= ACQUIRE;
                        run_reg   <= '0;
                    end
                    ACQUIRE: begin
                        if (match_next) begin
                            if (run_next >= LOCK_TGT) begin
                                state_reg  <= LOCKED;
                                locked_reg <= 1'b1;
                                run_reg    <= '0;
                                miss_reg   <= '0;
                            end else begin
                                run_reg <= run_next;
                            end
                        end else begin
                            run_reg <= '0;
                        end
                    end
                    LOCKED: begin
                        if (match_next) begin
                            miss_reg <= '0;
                        end else begin
                            err_pulse_reg <= 1'b1;
                            if (err_count_reg != ERR_MAX) begin
                                err_count_reg <= err_count_reg + 1'b1;
                            end
                            // The miss that drops lock is still pulsed and counted above.
                            if (miss_next >= MISS_TGT) begin
                                state_reg  <= ACQUIRE;
                                locked_reg <= 1'b0;
                                run_reg    <= '0;
                                miss_reg   <= '0;
                            end else begin
                                miss_reg <= miss_next;
                            end
                        end
                    end
                    default: begin
                        state_reg  <= IDLE;
                        locked_reg <= 1'b0;
                        run_reg    <= '0;
                        miss_reg   <= '0;
                    end
                endcase
            end
        end
    end

    assign locked     = locked_reg;
    assign err_pulse  = err_pulse_reg;
    assign err_count  = err_count_reg;
    assign last_count = last_count_reg;

endmodule
